// File: rtl/mem_bus_mux.sv
// Routes the arbiter-granted master onto one shared memory slave and returns its response.
// Optional MEM_BUS_MUX_RESP_REG_EN inserts a one-entry response register between slave and master.
module mem_bus_mux #(
  parameter int PORTS = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORTS-1:0]           m_req_valid,
  output logic [PORTS-1:0]           m_req_ready,
  input  logic [PORTS*AW-1:0]        m_req_addr,
  input  logic [PORTS-1:0]           m_req_wen,
  input  logic [PORTS*DW-1:0]        m_req_wdata,
  input  logic [PORTS*DW/8-1:0]      m_req_wmask,
  output logic [PORTS-1:0]           m_resp_valid,
  input  logic [PORTS-1:0]           m_resp_ready,
  output logic [DW-1:0]              m_resp_rdata,
  output logic [PORTS-1:0]           arb_request,
  output logic [PORTS-1:0]           arb_acknowledge,
  input  logic [PORTS-1:0]           arb_grant,
  input  logic                       arb_grant_valid,
  input  logic [$clog2(PORTS)-1:0]   arb_grant_encoded,
  output logic                       s_req_valid,
  input  logic                       s_req_ready,
  output logic [AW-1:0]              s_req_addr,
  output logic                       s_req_wen,
  output logic [DW-1:0]              s_req_wdata,
  output logic [DW/8-1:0]            s_req_wmask,
  input  logic                       s_resp_valid,
  output logic                       s_resp_ready,
  input  logic [DW-1:0]              s_resp_rdata
);

  localparam int SW = $clog2(PORTS);
  localparam int MW = DW / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  sel_q, sel_d;

  logic [PORTS-1:0] sel_oh;
  logic [AW-1:0]    sel_addr;
  logic             sel_wen;
  logic [DW-1:0]    sel_wdata;
  logic [MW-1:0]    sel_wmask;

`ifdef MEM_BUS_MUX_RESP_REG_EN
  logic          resp_full_q, resp_full_d;
  logic [DW-1:0] resp_data_q, resp_data_d;
`endif

  always_comb begin
    sel_oh    = '0;
    sel_addr  = '0;
    sel_wen   = 1'b0;
    sel_wdata = '0;
    sel_wmask = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (sel_q == SW'(i)) begin
        sel_oh[i] = 1'b1;
        sel_addr  = m_req_addr[i*AW +: AW];
        sel_wen   = m_req_wen[i];
        sel_wdata = m_req_wdata[i*DW +: DW];
        sel_wmask = m_req_wmask[i*MW +: MW];
      end
    end
  end

  // Outputs are held at zero while rst is high so reset takes effect combinationally.
  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    m_req_ready     = '0;
    m_resp_valid    = '0;
    m_resp_rdata    = '0;
    arb_request     = '0;
    arb_acknowledge = '0;
    s_req_valid     = 1'b0;
    s_req_addr      = '0;
    s_req_wen       = 1'b0;
    s_req_wdata     = '0;
    s_req_wmask     = '0;
    s_resp_ready    = 1'b0;
`ifdef MEM_BUS_MUX_RESP_REG_EN
    resp_full_d     = resp_full_q;
    resp_data_d     = resp_data_q;
`endif
    if (!rst) begin
      case (state_q)
        IDLE: begin
          arb_request = m_req_valid;
          if (arb_grant_valid) begin
            if ((arb_grant & m_req_valid) != '0) begin
              sel_d   = arb_grant_encoded;
              state_d = ISSUE;
            end else begin
              arb_acknowledge = arb_grant;
            end
          end
        end
        ISSUE: begin
          s_req_valid = 1'b1;
          s_req_addr  = sel_addr;
          s_req_wen   = sel_wen;
          s_req_wdata = sel_wdata;
          s_req_wmask = sel_wmask;
          m_req_ready = sel_oh & {PORTS{s_req_ready}};
          if (s_req_ready) state_d = RESP;
        end
        RESP: begin
`ifdef MEM_BUS_MUX_RESP_REG_EN
          s_resp_ready = !resp_full_q;
          if (s_resp_valid && !resp_full_q) begin
            resp_full_d = 1'b1;
            resp_data_d = s_resp_rdata;
          end
          m_resp_valid = sel_oh & {PORTS{resp_full_q}};
          m_resp_rdata = resp_data_q;
          if (resp_full_q && ((m_resp_ready & sel_oh) != '0)) begin
            resp_full_d     = 1'b0;
            arb_acknowledge = sel_oh;
            state_d         = IDLE;
          end
`else
          s_resp_ready = |(m_resp_ready & sel_oh);
          m_resp_valid = sel_oh & {PORTS{s_resp_valid}};
          m_resp_rdata = s_resp_rdata;
          if (s_resp_valid && ((m_resp_ready & sel_oh) != '0)) begin
            arb_acknowledge = sel_oh;
            state_d         = IDLE;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
`ifdef MEM_BUS_MUX_RESP_REG_EN
      resp_full_q <= 1'b0;
      resp_data_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
`ifdef MEM_BUS_MUX_RESP_REG_EN
      resp_full_q <= resp_full_d;
      resp_data_q <= resp_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_bus_mux.sv
// Scoreboard bench for mem_bus_mux with behavioural arbiter and slave models.
module tb_mem_bus_mux;

  localparam int PORTS = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int MW    = DW / 8;
`ifdef MEM_BUS_MUX_RESP_REG_EN
  localparam int RESP_LAT = 5;
`else
  localparam int RESP_LAT = 4;
`endif

  logic                  clk;
  logic                  rst;
  logic [PORTS-1:0]      m_req_valid;
  logic [PORTS-1:0]      m_req_ready;
  logic [PORTS*AW-1:0]   m_req_addr;
  logic [PORTS-1:0]      m_req_wen;
  logic [PORTS*DW-1:0]   m_req_wdata;
  logic [PORTS*MW-1:0]   m_req_wmask;
  logic [PORTS-1:0]      m_resp_valid;
  logic [PORTS-1:0]      m_resp_ready;
  logic [DW-1:0]         m_resp_rdata;
  logic [PORTS-1:0]      arb_request;
  logic [PORTS-1:0]      arb_acknowledge;
  logic [PORTS-1:0]      arb_grant;
  logic                  arb_grant_valid;
  logic [0:0]            arb_grant_encoded;
  logic                  s_req_valid;
  logic                  s_req_ready;
  logic [AW-1:0]         s_req_addr;
  logic                  s_req_wen;
  logic [DW-1:0]         s_req_wdata;
  logic [MW-1:0]         s_req_wmask;
  logic                  s_resp_valid;
  logic                  s_resp_ready;
  logic [DW-1:0]         s_resp_rdata;

  mem_bus_mux #(.PORTS(PORTS), .AW(AW), .DW(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .m_req_valid       (m_req_valid),
    .m_req_ready       (m_req_ready),
    .m_req_addr        (m_req_addr),
    .m_req_wen         (m_req_wen),
    .m_req_wdata       (m_req_wdata),
    .m_req_wmask       (m_req_wmask),
    .m_resp_valid      (m_resp_valid),
    .m_resp_ready      (m_resp_ready),
    .m_resp_rdata      (m_resp_rdata),
    .arb_request       (arb_request),
    .arb_acknowledge   (arb_acknowledge),
    .arb_grant         (arb_grant),
    .arb_grant_valid   (arb_grant_valid),
    .arb_grant_encoded (arb_grant_encoded),
    .s_req_valid       (s_req_valid),
    .s_req_ready       (s_req_ready),
    .s_req_addr        (s_req_addr),
    .s_req_wen         (s_req_wen),
    .s_req_wdata       (s_req_wdata),
    .s_req_wmask       (s_req_wmask),
    .s_resp_valid      (s_resp_valid),
    .s_resp_ready      (s_resp_ready),
    .s_resp_rdata      (s_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t req_q0[$], req_q1[$], resp_q0[$], resp_q1[$];
  int   issue_log[$];

  int checks = 0;
  int errors = 0;

  int cyc, ack_cycles, resp1_seen, ready_bad, stall_seen, stall_bad, resp_cnt, last_resp_cyc;
  logic [DW-1:0] last_rdata;
  logic [AW-1:0] stall_addr_ref;
  logic [PORTS-1:0] snap_m_resp_valid, snap_ack;
  logic snap_s_resp_ready, snap_s_req_valid;

  // Arbiter and slave knobs
  logic pref;
  logic inject;
  int   req_stall;
  int   stall_cnt;

  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    return (a == 32'h8000_0000) ? 32'h1234_5678 : (a ^ 32'hDEAD_BEEF);
  endfunction

  // Registered, blocking-on-acknowledge arbiter with a fixed winner on contention
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_grant_valid <= 1'b0;
      arb_grant       <= '0;
    end else if (inject) begin
      arb_grant_valid <= 1'b1;
      arb_grant       <= 2'b10;
    end else if (!arb_grant_valid || ((arb_acknowledge & arb_grant) != '0)) begin
      if (arb_request[pref]) begin
        arb_grant_valid <= 1'b1;
        arb_grant       <= pref ? 2'b10 : 2'b01;
      end else if (arb_request[!pref]) begin
        arb_grant_valid <= 1'b1;
        arb_grant       <= pref ? 2'b01 : 2'b10;
      end else begin
        arb_grant_valid <= 1'b0;
        arb_grant       <= '0;
      end
    end
  end
  assign arb_grant_encoded = arb_grant[1];

  // Slave: accepts after req_stall wait cycles, responds the following cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_resp_valid <= 1'b0;
      s_resp_rdata <= '0;
      stall_cnt    <= 0;
    end else begin
      if (s_req_valid && s_req_ready) begin
        s_resp_valid <= 1'b1;
        s_resp_rdata <= slave_data(s_req_addr);
      end else if (s_resp_valid && s_resp_ready) begin
        s_resp_valid <= 1'b0;
      end
      stall_cnt <= (s_req_valid && !s_req_ready) ? stall_cnt + 1 : 0;
    end
  end
  assign s_req_ready = (stall_cnt >= req_stall);

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int m, input logic [AW-1:0] addr, input logic wen,
                               input logic [DW-1:0] wdata, input logic [MW-1:0] wmask);
    txn_t t;
    t.addr  = addr;
    t.wen   = wen;
    t.wdata = wdata;
    t.wmask = wmask;
    t.rdata = slave_data(addr);
    m_req_addr[m*AW +: AW]  = addr;
    m_req_wen[m]            = wen;
    m_req_wdata[m*DW +: DW] = wdata;
    m_req_wmask[m*MW +: MW] = wmask;
    m_req_valid[m]          = 1'b1;
    if (m == 0) req_q0.push_back(t);
    else        req_q1.push_back(t);
  endtask

  // One clock: sample and score at negedge, then drop accepted master requests after posedge
  task automatic cycle();
    logic [PORTS-1:0] drop;
    txn_t t;
    int m;
    @(negedge clk);
    cyc++;
    snap_m_resp_valid = m_resp_valid;
    snap_ack          = arb_acknowledge;
    snap_s_resp_ready = s_resp_ready;
    snap_s_req_valid  = s_req_valid;
    drop = m_req_valid & m_req_ready;
    if (arb_acknowledge != '0) ack_cycles++;
    if (m_resp_valid[1]) resp1_seen++;
    if (m_req_ready != '0 && !(s_req_valid && s_req_ready)) ready_bad++;
    if (s_req_valid && !s_req_ready) begin
      stall_seen++;
      if (s_req_addr !== stall_addr_ref || m_req_ready != '0) stall_bad++;
    end
    if (s_req_valid && s_req_ready) begin
      m = (m_req_ready == 2'b10) ? 1 : 0;
      checkOutput("issue_ready_onehot", {62'd0, m_req_ready}, m ? 64'd2 : 64'd1);
      if ((m == 0 && req_q0.size() == 0) || (m == 1 && req_q1.size() == 0)) begin
        checkOutput("issue_unexpected", 64'd1, 64'd0);
      end else begin
        t = (m == 0) ? req_q0.pop_front() : req_q1.pop_front();
        checkOutput("s_req_addr", {32'd0, s_req_addr}, {32'd0, t.addr});
        checkOutput("s_req_wen", {63'd0, s_req_wen}, {63'd0, t.wen});
        if (t.wen) begin
          checkOutput("s_req_wdata", {32'd0, s_req_wdata}, {32'd0, t.wdata});
          checkOutput("s_req_wmask", {60'd0, s_req_wmask}, {60'd0, t.wmask});
        end
        issue_log.push_back(m);
        if (m == 0) resp_q0.push_back(t);
        else        resp_q1.push_back(t);
      end
    end
    for (int i = 0; i < PORTS; i++) begin
      if (m_resp_valid[i] && m_resp_ready[i]) begin
        resp_cnt++;
        last_resp_cyc = cyc;
        last_rdata    = m_resp_rdata;
        checkOutput("resp_ack", {62'd0, arb_acknowledge}, (i == 0) ? 64'd1 : 64'd2);
        if ((i == 0 && resp_q0.size() == 0) || (i == 1 && resp_q1.size() == 0)) begin
          checkOutput("resp_unexpected", 64'd1, 64'd0);
        end else begin
          t = (i == 0) ? resp_q0.pop_front() : resp_q1.pop_front();
          if (!t.wen) checkOutput("m_resp_rdata", {32'd0, m_resp_rdata}, {32'd0, t.rdata});
        end
      end
    end
    @(posedge clk);
    #1;
    m_req_valid = m_req_valid & ~drop;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((m_req_valid != '0 || req_q0.size() != 0 || req_q1.size() != 0 ||
            resp_q0.size() != 0 || resp_q1.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) checkOutput("idle_timeout", 64'd1, 64'd0);
    cycle();
  endtask

  task automatic clearCounters();
    ack_cycles = 0;
    resp1_seen = 0;
    stall_seen = 0;
    stall_bad  = 0;
    resp_cnt   = 0;
    issue_log.delete();
  endtask

  initial begin
    int start;
    int found;
    rst = 1'b1;
    m_req_valid = 2'b11;
    m_req_addr = '0; m_req_wen = '0; m_req_wdata = '0; m_req_wmask = '0;
    m_resp_ready = 2'b11;
    pref = 1'b0; inject = 1'b0; req_stall = 0;
    cyc = 0; ready_bad = 0; last_resp_cyc = 0; last_rdata = '0;
    stall_addr_ref = '0;
    clearCounters();

    // Reset state, with both masters requesting
    #12;
    checkOutput("rst_arb_request", {62'd0, arb_request}, 64'd0);
    checkOutput("rst_m_req_ready", {62'd0, m_req_ready}, 64'd0);
    checkOutput("rst_m_resp_valid", {62'd0, m_resp_valid}, 64'd0);
    checkOutput("rst_arb_ack", {62'd0, arb_acknowledge}, 64'd0);
    checkOutput("rst_s_req_valid", {63'd0, s_req_valid}, 64'd0);
    checkOutput("rst_s_resp_ready", {63'd0, s_resp_ready}, 64'd0);
    checkOutput("rst_s_req_addr", {32'd0, s_req_addr}, 64'd0);
    checkOutput("rst_s_req_wdata", {32'd0, s_req_wdata}, 64'd0);
    checkOutput("rst_m_resp_rdata", {32'd0, m_resp_rdata}, 64'd0);
    m_req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();

    // Single read from master 0
    clearCounters();
    applyStimulus(0, 32'h8000_0000, 1'b0, '0, '0);
    start = cyc;
    waitIdle(40);
    checkOutput("single_rdata", {32'd0, last_rdata}, 64'h1234_5678);
    checkOutput("single_ack_cycles", ack_cycles, 1);
    checkOutput("single_resp1_seen", resp1_seen, 0);
    checkOutput("single_latency", last_resp_cyc - start, RESP_LAT);

    // Contention: arbiter favours master 1
    clearCounters();
    pref = 1'b1;
    applyStimulus(0, 32'h1000_0040, 1'b0, '0, '0);
    applyStimulus(1, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 4'hF);
    waitIdle(60);
    checkOutput("cont_issues", issue_log.size(), 2);
    if (issue_log.size() == 2) begin
      checkOutput("cont_first", issue_log[0], 1);
      checkOutput("cont_second", issue_log[1], 0);
    end
    checkOutput("cont_ack_cycles", ack_cycles, 2);
    pref = 1'b0;

    // Slave request backpressure for 5 cycles
    clearCounters();
    req_stall = 5;
    stall_addr_ref = 32'h0000_0C00;
    applyStimulus(1, 32'h0000_0C00, 1'b1, 32'hCAFE_F00D, 4'h3);
    waitIdle(60);
    checkOutput("bp_stall_cycles", stall_seen, 5);
    checkOutput("bp_field_hold", stall_bad, 0);
    req_stall = 0;

    // Master 1 stalls its response for 4 cycles
    clearCounters();
    m_resp_ready = 2'b01;
    applyStimulus(1, 32'h0000_0100, 1'b0, '0, '0);
    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      cycle();
      if (snap_m_resp_valid[1]) found = 1;
    end
    checkOutput("mstall_resp_seen", found, 1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cycle();
      checkOutput("mstall_resp_valid", {62'd0, snap_m_resp_valid}, 64'd2);
      checkOutput("mstall_s_resp_ready", {63'd0, snap_s_resp_ready}, 64'd0);
      checkOutput("mstall_no_ack", {62'd0, snap_ack}, 64'd0);
    end
    m_resp_ready = 2'b11;
    cycle();
    checkOutput("mstall_release_ack", {62'd0, snap_ack}, 64'd2);
    waitIdle(20);
    checkOutput("mstall_ack_cycles", ack_cycles, 1);

    // Stale grant with no master requesting
    clearCounters();
    inject = 1'b1;
    cycle();
    inject = 1'b0;
    cycle();
    checkOutput("stale_ack", {62'd0, snap_ack}, 64'd2);
    checkOutput("stale_no_req", {63'd0, snap_s_req_valid}, 64'd0);
    cycle();
    checkOutput("stale_ack_drop", {62'd0, snap_ack}, 64'd0);
    checkOutput("stale_no_req2", {63'd0, snap_s_req_valid}, 64'd0);
    applyStimulus(1, 32'h0000_2000, 1'b0, '0, '0);
    start = cyc;
    waitIdle(40);
    checkOutput("stale_next_latency", last_resp_cyc - start, RESP_LAT);

    // Reset while a response is pending for master 0
    clearCounters();
    m_resp_ready = 2'b10;
    applyStimulus(0, 32'h0000_4000, 1'b0, '0, '0);
    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      cycle();
      if (snap_m_resp_valid[0]) found = 1;
    end
    checkOutput("rresp_pending", found, 1);
    rst = 1'b1;
    #1;
    checkOutput("rresp_m_resp_valid", {62'd0, m_resp_valid}, 64'd0);
    checkOutput("rresp_s_resp_ready", {63'd0, s_resp_ready}, 64'd0);
    checkOutput("rresp_arb_ack", {62'd0, arb_acknowledge}, 64'd0);
    checkOutput("rresp_m_resp_rdata", {32'd0, m_resp_rdata}, 64'd0);
    checkOutput("rresp_s_req_valid", {63'd0, s_req_valid}, 64'd0);
    req_q0.delete(); req_q1.delete(); resp_q0.delete(); resp_q1.delete();
    m_req_valid = 2'b00;
    m_resp_ready = 2'b11;
    @(posedge clk); #1;
    rst = 1'b0;
    clearCounters();
    applyStimulus(1, 32'h0000_3000, 1'b0, '0, '0);
    waitIdle(40);
    checkOutput("rresp_after_cnt", resp_cnt, 1);
    checkOutput("rresp_after_ack", ack_cycles, 1);

    // Mixed traffic from both masters
    clearCounters();
    for (int n = 0; n < 8; n++) begin
      int m;
      logic [AW-1:0] a;
      m = $urandom_range(0, 1);
      a = {$urandom_range(0, 65535), 16'h0} | AW'(n * 4);
      pref = 1'($urandom_range(0, 1));
      applyStimulus(m, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)));
      waitIdle(60);
    end
    checkOutput("mixed_resp_cnt", resp_cnt, 8);

    checkOutput("ready_spurious", ready_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
